cache_axi_arbiter: RTL and testbench
====================================

Name: cache_axi_arbiter

Overview:
- Shares the single axi_ctl refill/writeback channel between the icache (read-only line fills) and the dcache (dirty-line writeback plus line refill).
- Grants one cache at a time and forwards that owner's request, address, direction and fifo handshakes to axi_ctl.
- Routes axi_ctl completion and data back only to the owner.
- Sits between both caches and axi_ctl in the core memory path.

Parameters:
- ADDR_W, 64, width of request addresses.
- DATA_W, 64, width of fifo data beats.
- IDX_W, 9, width of axi_fifo_idx.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  icache line-fill request, level, held until done observed
- i_addr  in  ADDR_W  icache block address
- i_done  out  1  axi_done routed to icache
- i_fifo_wen  out  1  axi_fifo_wen routed to icache
- i_data  out  DATA_W  axi_data_i routed to icache
- i_fifo_idx  in  IDX_W  icache fifo read index
- i_fifo_done  in  1  icache finished draining fifo
- d_req  in  1  dcache request, level, held across writeback and refill
- d_rw  in  1  dcache direction, 0 read, 1 write
- d_addr  in  ADDR_W  dcache block address
- d_wdata  in  DATA_W  dcache writeback beat
- d_fifo_wen  in  1  dcache pushes writeback beat
- d_fifo_idx  in  IDX_W  dcache fifo index
- d_fifo_done  in  1  dcache fifo phase complete
- d_done  out  1  axi_done routed to dcache
- d_fifo_ren  out  1  axi_fifo_wen routed to dcache
- d_rdata  out  DATA_W  axi_data_i routed to dcache
- axi_req  out  1  request to axi_ctl
- axi_rw  out  1  direction to axi_ctl
- axi_req_addr  out  ADDR_W  address to axi_ctl
- axi_data_o  out  DATA_W  write beat to axi_ctl
- axi_fifo_wen_o  out  1  write-beat strobe to axi_ctl
- axi_fifo_idx  out  IDX_W  fifo index to axi_ctl
- axi_fifo_done  out  1  fifo-done to axi_ctl
- axi_done  in  1  axi_ctl transaction complete
- axi_fifo_wen  in  1  axi_ctl read-beat strobe
- axi_data_i  in  DATA_W  axi_ctl read beat
- busy  out  1  grant active (state != IDLE)
- owner  out  1  current or last owner, 0 icache, 1 dcache

Behaviour:
- FSM states: IDLE, GRANT, RELEASE. Reset sets state IDLE, owner 0, busy 0, and drives every axi_* and requester output to 0.
- IDLE:
  - If any request is pending at a clk edge, latch owner and enter GRANT.
  - Without the optional feature, dcache wins when both requests are present.
  - axi_req rises 1 cycle after the owner's req is sampled (registered).
- GRANT:
  - axi_req is a registered copy of the owner's req.
  - axi_rw, axi_req_addr, axi_data_o, axi_fifo_wen_o, axi_fifo_idx and axi_fifo_done are combinational from the owner's inputs.
  - For icache ownership, axi_rw=0, axi_data_o=0 and axi_fifo_wen_o=0.
  - axi_done, axi_fifo_wen and axi_data_i are steered to the owner; the non-owner sees done=0, strobe=0, data=0.
  - The owner may change d_rw while holding req (writeback then refill); grant is retained.
  - Leave to RELEASE when the owner's req is sampled low.
- RELEASE:
  - Exactly 1 cycle with axi_req=0 and all axi_* outputs at 0, guaranteeing an axi_ctl deassert gap.
  - Then IDLE.
  - A request already pending is granted on the following edge, so back-to-back ownership switches cost 2 idle cycles.
- A non-owner request raised during GRANT is held pending and never dropped; no preemption.
- Owner req drop coincident with axi_done:
  - done is still delivered that cycle.
  - The next cycle is RELEASE.
- Reset mid-GRANT: next edge forces IDLE with axi_req=0; in-flight axi_ctl state is axi_ctl's responsibility.
- busy=1 in GRANT and RELEASE.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- When defined, a simultaneous i_req/d_req in IDLE is granted to the cache that was not the last owner; the last-owner register resets to icache, so the first tie goes to dcache.
- When not defined, fixed priority applies: dcache always wins ties.
- Single requests are unaffected either way.

Test Plan:
- Reset then i_req=1, i_addr=0x8000_0040 -> axi_req=1 one cycle later, axi_rw=0, axi_req_addr=0x8000_0040. Pulse axi_done -> i_done=1, d_done=0. Drop i_req -> one RELEASE cycle with axi_req=0, then IDLE, busy=0.
- d_req with d_rw=1, 8 beats of d_wdata 0x1..0x8 with d_fifo_wen -> axi_data_o/axi_fifo_wen_o match beat-for-beat. Then d_rw flips to 0 under held d_req -> grant kept, axi_rw=0, axi_data_i beats appear on d_rdata only.
- i_req and d_req asserted the same cycle, macro off -> owner=1 (dcache). After dcache drops req -> icache granted exactly 2 cycles later.
- Same simultaneous stimulus repeated twice with ARB_ROUND_ROBIN_EN -> first grant dcache, second grant icache.
- During a dcache grant, i_req asserted for 20 cycles -> no axi_req glitch or owner change until d_req drops; icache served after.
- rst asserted mid-GRANT with axi_req=1 -> next cycle axi_req=0, busy=0, owner=0, all requester outputs 0.

Source files
------------

// File: rtl/cache_axi_arbiter_if.sv
// Handshake bundle between the icache, the dcache and axi_ctl, as seen by the refill/writeback arbiter.
// slave = arbiter side, master = environment side (caches plus axi_ctl).
interface cache_axi_arbiter_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned IDX_W  = 9
);
   // icache side
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_done;
   logic              i_fifo_wen;
   logic [DATA_W-1:0] i_data;
   logic [IDX_W-1:0]  i_fifo_idx;
   logic              i_fifo_done;

   // dcache side
   logic              d_req;
   logic              d_rw;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_fifo_wen;
   logic [IDX_W-1:0]  d_fifo_idx;
   logic              d_fifo_done;
   logic              d_done;
   logic              d_fifo_ren;
   logic [DATA_W-1:0] d_rdata;

   // axi_ctl side
   logic              axi_req;
   logic              axi_rw;
   logic [ADDR_W-1:0] axi_req_addr;
   logic [DATA_W-1:0] axi_data_o;
   logic              axi_fifo_wen_o;
   logic [IDX_W-1:0]  axi_fifo_idx;
   logic              axi_fifo_done;
   logic              axi_done;
   logic              axi_fifo_wen;
   logic [DATA_W-1:0] axi_data_i;

   modport slave (
      input  i_req, i_addr, i_fifo_idx, i_fifo_done,
      input  d_req, d_rw, d_addr, d_wdata, d_fifo_wen, d_fifo_idx, d_fifo_done,
      input  axi_done, axi_fifo_wen, axi_data_i,
      output i_done, i_fifo_wen, i_data,
      output d_done, d_fifo_ren, d_rdata,
      output axi_req, axi_rw, axi_req_addr, axi_data_o, axi_fifo_wen_o, axi_fifo_idx, axi_fifo_done
   );

   modport master (
      output i_req, i_addr, i_fifo_idx, i_fifo_done,
      output d_req, d_rw, d_addr, d_wdata, d_fifo_wen, d_fifo_idx, d_fifo_done,
      output axi_done, axi_fifo_wen, axi_data_i,
      input  i_done, i_fifo_wen, i_data,
      input  d_done, d_fifo_ren, d_rdata,
      input  axi_req, axi_rw, axi_req_addr, axi_data_o, axi_fifo_wen_o, axi_fifo_idx, axi_fifo_done
   );
endinterface

// File: rtl/cache_axi_arbiter.sv
// Arbitrates the single axi_ctl refill/writeback channel between icache and dcache.
// Optional macro ARB_ROUND_ROBIN_EN: ties go to the cache that was not the last owner (default: dcache wins ties).
module cache_axi_arbiter #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned IDX_W  = 9
) (
   input  logic                clk,
   input  logic                rst,
   cache_axi_arbiter_if.slave  bus,
   output logic                busy,
   output logic                owner
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   state_t state;
   state_t state_next;
   logic   owner_next;
   logic   busy_next;
   logic   axi_req_q;
   logic   axi_req_next;
   logic   owner_req_c;
   logic   tie_owner_c;

   // Forwarded request-side fields and steered completion-side fields.
   logic              rw_c;
   logic [ADDR_W-1:0] addr_c;
   logic [DATA_W-1:0] data_o_c;
   logic              wen_o_c;
   logic [IDX_W-1:0]  idx_c;
   logic              fdone_c;
   logic              i_done_c;
   logic              i_wen_c;
   logic [DATA_W-1:0] i_data_c;
   logic              d_done_c;
   logic              d_ren_c;
   logic [DATA_W-1:0] d_data_c;

   // Tie-break between simultaneous requests seen in IDLE.
`ifdef ARB_ROUND_ROBIN_EN
   assign tie_owner_c = ~owner;
`else
   assign tie_owner_c = OWN_D;
`endif

   assign owner_req_c = (owner == OWN_D) ? bus.d_req : bus.i_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= OWN_I;
         busy      <= 1'b0;
         axi_req_q <= 1'b0;
      end else begin
         state     <= state_next;
         owner     <= owner_next;
         busy      <= busy_next;
         axi_req_q <= axi_req_next;
      end
   end

   always_comb begin
      state_next = state;
      owner_next = owner;
      case (state)
         IDLE: begin
            if (bus.i_req && bus.d_req) begin
               owner_next = tie_owner_c;
               state_next = GRANT;
            end else if (bus.d_req) begin
               owner_next = OWN_D;
               state_next = GRANT;
            end else if (bus.i_req) begin
               owner_next = OWN_I;
               state_next = GRANT;
            end
         end
         GRANT: begin
            if (!owner_req_c) state_next = RELEASE;
         end
         RELEASE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      // axi_req follows the owner's sampled req; RELEASE forces the deassert gap.
      axi_req_next = (state_next == GRANT);
      busy_next    = (state_next != IDLE);
   end

   // Owner's request fields go out, axi_ctl responses come back only to the owner.
   always_comb begin
      rw_c     = 1'b0;
      addr_c   = '0;
      data_o_c = '0;
      wen_o_c  = 1'b0;
      idx_c    = '0;
      fdone_c  = 1'b0;
      i_done_c = 1'b0;
      i_wen_c  = 1'b0;
      i_data_c = '0;
      d_done_c = 1'b0;
      d_ren_c  = 1'b0;
      d_data_c = '0;
      if (state == GRANT) begin
         if (owner == OWN_D) begin
            rw_c     = bus.d_rw;
            addr_c   = bus.d_addr;
            data_o_c = bus.d_wdata;
            wen_o_c  = bus.d_fifo_wen;
            idx_c    = bus.d_fifo_idx;
            fdone_c  = bus.d_fifo_done;
            d_done_c = bus.axi_done;
            d_ren_c  = bus.axi_fifo_wen;
            d_data_c = bus.axi_data_i;
         end else begin
            addr_c   = bus.i_addr;
            idx_c    = bus.i_fifo_idx;
            fdone_c  = bus.i_fifo_done;
            i_done_c = bus.axi_done;
            i_wen_c  = bus.axi_fifo_wen;
            i_data_c = bus.axi_data_i;
         end
      end
   end

   assign bus.axi_req        = axi_req_q;
   assign bus.axi_rw         = rw_c;
   assign bus.axi_req_addr   = addr_c;
   assign bus.axi_data_o     = data_o_c;
   assign bus.axi_fifo_wen_o = wen_o_c;
   assign bus.axi_fifo_idx   = idx_c;
   assign bus.axi_fifo_done  = fdone_c;
   assign bus.i_done         = i_done_c;
   assign bus.i_fifo_wen     = i_wen_c;
   assign bus.i_data         = i_data_c;
   assign bus.d_done         = d_done_c;
   assign bus.d_fifo_ren     = d_ren_c;
   assign bus.d_rdata        = d_data_c;

   // Structural invariants of the grant protocol.
   a_req_only_in_grant : assert property (@(posedge clk) disable iff (rst)
      bus.axi_req |-> (state == GRANT));
   a_single_done : assert property (@(posedge clk) disable iff (rst)
      !(bus.i_done && bus.d_done));
   a_release_one_cycle : assert property (@(posedge clk) disable iff (rst)
      (state == RELEASE) |=> (state == IDLE));

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Scoreboard bench for cache_axi_arbiter: stimulus queues expected events, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_cache_axi_arbiter;
   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned IDX_W  = 9;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic owner;
   int unsigned cyc = 0;
   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cache_axi_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

   cache_axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .busy  (busy),
      .owner (owner)
   );

   typedef struct {
      int unsigned       cyc;
      logic              own;
      logic              rw;
      logic [ADDR_W-1:0] addr;
   } grant_t;

   grant_t            q_grant[$];
   int unsigned       q_idone[$];
   int unsigned       q_ddone[$];
   logic [DATA_W-1:0] q_wbeat[$];
   logic [DATA_W-1:0] q_drd[$];
   logic [DATA_W-1:0] q_ird[$];

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endfunction

   function automatic void miss(string name);
      n_total++;
      $display("FAIL %s: got an event, expected none queued", name);
   endfunction

   // Monitor: every DUT-presented event must match the head of its queue.
   logic prev_req = 1'b0;
   always @(negedge clk) begin
      grant_t g;
      if (bus.axi_req && !prev_req) begin
         if (q_grant.size() == 0) miss("grant");
         else begin
            g = q_grant.pop_front();
            n_total++;
            if (cyc == g.cyc && owner == g.own && bus.axi_rw == g.rw && bus.axi_req_addr == g.addr)
               n_pass++;
            else
               $display("FAIL grant: got cyc=%0d owner=%0b rw=%0b addr=0x%0h expected cyc=%0d owner=%0b rw=%0b addr=0x%0h",
                        cyc, owner, bus.axi_rw, bus.axi_req_addr, g.cyc, g.own, g.rw, g.addr);
         end
      end
      prev_req = bus.axi_req;
      if (bus.i_done) begin
         if (q_idone.size() == 0) miss("i_done");
         else chk("i_done_cyc", 64'(cyc), 64'(q_idone.pop_front()));
      end
      if (bus.d_done) begin
         if (q_ddone.size() == 0) miss("d_done");
         else chk("d_done_cyc", 64'(cyc), 64'(q_ddone.pop_front()));
      end
      if (bus.axi_fifo_wen_o) begin
         if (q_wbeat.size() == 0) miss("axi_wbeat");
         else chk("axi_data_o", bus.axi_data_o, q_wbeat.pop_front());
      end
      if (bus.d_fifo_ren) begin
         if (q_drd.size() == 0) miss("d_rbeat");
         else chk("d_rdata", bus.d_rdata, q_drd.pop_front());
      end
      if (bus.i_fifo_wen) begin
         if (q_ird.size() == 0) miss("i_rbeat");
         else chk("i_data", bus.i_data, q_ird.pop_front());
      end
   end

   task automatic step(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      bus.i_req = 1'b0;        bus.i_addr = '0;      bus.i_fifo_idx = '0;  bus.i_fifo_done = 1'b0;
      bus.d_req = 1'b0;        bus.d_rw = 1'b0;      bus.d_addr = '0;      bus.d_wdata = '0;
      bus.d_fifo_wen = 1'b0;   bus.d_fifo_idx = '0;  bus.d_fifo_done = 1'b0;
      bus.axi_done = 1'b0;     bus.axi_fifo_wen = 1'b0; bus.axi_data_i = '0;
   endtask

   task automatic push_grant(int unsigned c, logic o, logic r, logic [ADDR_W-1:0] a);
      grant_t g;
      g.cyc = c; g.own = o; g.rw = r; g.addr = a;
      q_grant.push_back(g);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
   endtask

   localparam logic [ADDR_W-1:0] IA = 64'h0000_0000_8000_0040;
   localparam logic [ADDR_W-1:0] DA = 64'h0000_0000_1000_0080;

   initial begin
      logic exp_own;
      clear_in();
      rst = 1'b1;
      step(3);
      @(negedge clk);
      chk("rst_axi_req", 64'(bus.axi_req), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_owner", 64'(owner), 64'd0);
      rst = 1'b0;
      step(1);

      // icache fill: grant, beat, done, release gap
      bus.i_req = 1'b1; bus.i_addr = IA;
      push_grant(cyc + 1, 1'b0, 1'b0, IA);
      step(1);
      bus.i_fifo_idx = 9'h055; bus.i_fifo_done = 1'b1;
      @(negedge clk);
      chk("busy_grant", 64'(busy), 64'd1);
      chk("i_fifo_idx_fwd", 64'(bus.axi_fifo_idx), 64'h55);
      chk("i_fifo_done_fwd", 64'(bus.axi_fifo_done), 64'd1);
      step(1);
      bus.i_fifo_done = 1'b0; bus.i_fifo_idx = '0;
      bus.axi_fifo_wen = 1'b1; bus.axi_data_i = 64'h1111;
      q_ird.push_back(64'h1111);
      @(negedge clk);
      chk("d_rdata_quiet", bus.d_rdata, 64'd0);
      step(1);
      bus.axi_fifo_wen = 1'b0; bus.axi_data_i = '0; bus.axi_done = 1'b1;
      q_idone.push_back(cyc);
      step(1);
      bus.axi_done = 1'b0; bus.i_req = 1'b0;
      step(1);
      @(negedge clk);
      chk("release_axi_req", 64'(bus.axi_req), 64'd0);
      chk("release_busy", 64'(busy), 64'd1);
      step(1);
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      step(1);

      // dcache writeback of 8 beats, then refill under the same grant
      bus.d_req = 1'b1; bus.d_rw = 1'b1; bus.d_addr = DA;
      push_grant(cyc + 1, 1'b1, 1'b1, DA);
      step(1);
      for (int k = 1; k <= 8; k++) begin
         bus.d_wdata = 64'(k); bus.d_fifo_wen = 1'b1; bus.d_fifo_idx = 9'(k);
         q_wbeat.push_back(64'(k));
         step(1);
      end
      bus.d_wdata = '0; bus.d_fifo_wen = 1'b0; bus.d_fifo_idx = '0;
      bus.axi_done = 1'b1;
      q_ddone.push_back(cyc);
      step(1);
      bus.axi_done = 1'b0; bus.d_rw = 1'b0;
      @(negedge clk);
      chk("refill_axi_rw", 64'(bus.axi_rw), 64'd0);
      chk("refill_keeps_grant", {62'd0, owner, bus.axi_req}, 64'd3);
      step(1);
      for (int k = 0; k < 4; k++) begin
         bus.axi_fifo_wen = 1'b1; bus.axi_data_i = 64'hA0 + 64'(k);
         q_drd.push_back(64'hA0 + 64'(k));
         @(negedge clk);
         chk("i_data_quiet", {bus.i_data[62:0], bus.i_fifo_wen}, 64'd0);
         step(1);
      end
      bus.axi_fifo_wen = 1'b0; bus.axi_data_i = '0; bus.axi_done = 1'b1;
      q_ddone.push_back(cyc);
      step(1);
      bus.axi_done = 1'b0; bus.d_req = 1'b0;
      step(3);

      // simultaneous requests: dcache first, icache granted 3 edges after dcache drops
      do_reset();
      bus.i_req = 1'b1; bus.i_addr = IA;
      bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_addr = DA;
      push_grant(cyc + 1, 1'b1, 1'b0, DA);
      step(4);
      bus.d_req = 1'b0;
      push_grant(cyc + 3, 1'b0, 1'b0, IA);
      step(1);
      @(negedge clk);
      chk("switch_gap1", 64'(bus.axi_req), 64'd0);
      step(1);
      @(negedge clk);
      chk("switch_gap2", 64'(bus.axi_req), 64'd0);
      step(2);
      // req drop coincident with axi_done still delivers done
      bus.axi_done = 1'b1; bus.i_req = 1'b0;
      q_idone.push_back(cyc);
      step(1);
      bus.axi_done = 1'b0;
      @(negedge clk);
      chk("drop_done_release", {62'd0, busy, bus.axi_req}, 64'd2);
      step(2);

      // two ties in a row, both dropped together
      do_reset();
      bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_rw = 1'b0;
      push_grant(cyc + 1, 1'b1, 1'b0, DA);
      step(2);
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      step(3);
`ifdef ARB_ROUND_ROBIN_EN
      exp_own = 1'b0;
`else
      exp_own = 1'b1;
`endif
      bus.i_req = 1'b1; bus.d_req = 1'b1;
      push_grant(cyc + 1, exp_own, 1'b0, exp_own ? DA : IA);
      step(2);
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      step(3);

      // no preemption: icache waits out a dcache grant
      bus.d_req = 1'b1; bus.d_rw = 1'b1;
      push_grant(cyc + 1, 1'b1, 1'b1, DA);
      step(1);
      bus.i_req = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("hold_dcache", {62'd0, owner, bus.axi_req}, 64'd3);
         step(1);
      end
      bus.d_req = 1'b0;
      push_grant(cyc + 3, 1'b0, 1'b0, IA);
      step(4);
      bus.i_req = 1'b0;
      step(3);

      // synchronous reset in the middle of a dcache grant
      bus.d_req = 1'b1; bus.d_rw = 1'b1;
      push_grant(cyc + 1, 1'b1, 1'b1, DA);
      step(2);
      @(negedge clk);
      chk("pre_rst_axi_req", 64'(bus.axi_req), 64'd1);
      rst = 1'b1;
      step(1);
      bus.axi_done = 1'b1; bus.axi_fifo_wen = 1'b1; bus.axi_data_i = 64'hDEAD;
      @(negedge clk);
      chk("rst_mid_axi_req", 64'(bus.axi_req), 64'd0);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_owner", 64'(owner), 64'd0);
      chk("rst_mid_d_out", {bus.d_rdata[61:0], bus.d_done, bus.d_fifo_ren}, 64'd0);
      chk("rst_mid_axi_out", bus.axi_req_addr | bus.axi_data_o | 64'(bus.axi_rw), 64'd0);
      clear_in();
      step(1);
      rst = 1'b0;
      step(3);

      chk("queues_drained", 64'(q_grant.size() + q_idone.size() + q_ddone.size()
                                + q_wbeat.size() + q_drd.size() + q_ird.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout at cycle %0d expected finish", cyc);
      $fatal(1);
   end
endmodule
